// File: rtl/crossbar_pkg.sv
// Shared types and default sizing for the crossbar arbiter blocks.
// Holds the arbiter state encoding and a helper for index widths.
package crossbar_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int DEF_NUM_MASTERS = 4;
  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_ADDR_WIDTH  = 32;
  localparam int DEF_MAX_BURST   = 4;

  // A master index needs at least one bit, even when there is a single master.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: finds the first set request at or after ptr,
// wrapping modulo N. Purely combinational.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] index
);

  // Scanning from the farthest offset down lets the nearest requester win last.
  always_comb begin
    int cand;
    cand  = 0;
    valid = 1'b0;
    index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = int'(ptr) + i;
      if (cand >= N) cand = cand - N;
      if (req[cand[IW-1:0]]) begin
        valid = 1'b1;
        index = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/slave_arbiter.sv
// Round-robin arbiter sharing one slave port among NUM_MASTERS masters,
// with at most MAX_BURST acknowledged transfers per grant.
module slave_arbiter
  import crossbar_pkg::*;
#(
  parameter int NUM_MASTERS = DEF_NUM_MASTERS,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int MAX_BURST   = DEF_MAX_BURST
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_MASTERS-1:0]            m_req,
  input  logic [NUM_MASTERS-1:0]            m_cmd,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_rdata,
  output logic [NUM_MASTERS-1:0]            m_ack,
  output logic                              s_cs,
  output logic                              s_cmd,
  output logic [ADDR_WIDTH-1:0]             s_addr,
  output logic [DATA_WIDTH-1:0]             s_wdata,
  input  logic [DATA_WIDTH-1:0]             s_rdata,
  input  logic                              s_ack
);

  localparam int IW = idx_width(NUM_MASTERS);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_MASTERS - 1);

  arb_state_t    state, next_state;
  logic [IW-1:0] grant_idx, next_grant_idx;
  logic [IW-1:0] ptr, next_ptr, ptr_after_grant;
  logic [BW-1:0] burst_cnt, next_burst_cnt;
  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic          gnt_req;
  logic          beat;

  rr_pick #(
    .N  (NUM_MASTERS),
    .IW (IW)
  ) u_pick (
    .req   (m_req),
    .ptr   (ptr),
    .valid (pick_valid),
    .index (pick_idx)
  );

  assign gnt_req         = m_req[grant_idx];
  assign beat            = (state == GRANT) && gnt_req && s_ack;
  assign ptr_after_grant = (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;

  // Slave-side signals come straight from the granted master; nothing is registered.
  always_comb begin
    s_cs    = 1'b0;
    m_ack   = '0;
    m_rdata = '0;
    s_cmd   = m_cmd[grant_idx];
    s_addr  = m_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
    s_wdata = m_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
    if (state == GRANT) begin
      s_cs                                         = gnt_req;
      m_ack[grant_idx]                             = beat;
      m_rdata[grant_idx*DATA_WIDTH +: DATA_WIDTH]  = s_rdata;
    end
  end

  always_comb begin
    next_state     = state;
    next_grant_idx = grant_idx;
    next_ptr       = ptr;
    next_burst_cnt = burst_cnt;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          next_state     = GRANT;
          next_grant_idx = pick_idx;
          next_burst_cnt = '0;
        end
      end
      GRANT: begin
        // A dropped request ends the grant without touching the slave.
        if (!gnt_req) begin
          next_state = IDLE;
          next_ptr   = ptr_after_grant;
        end else if (beat) begin
          next_burst_cnt = burst_cnt + 1'b1;
          if (burst_cnt == LAST_BEAT) begin
            next_state = IDLE;
            next_ptr   = ptr_after_grant;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant_idx <= '0;
      ptr       <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= next_state;
      grant_idx <= next_grant_idx;
      ptr       <= next_ptr;
      burst_cnt <= next_burst_cnt;
    end
  end

endmodule

// File: tb/tb_slave_arbiter.sv
// Directed scoreboard bench for slave_arbiter: expected grants are queued by
// the stimulus and matched by a monitor on every master acknowledge.
module tb_slave_arbiter;

  localparam int NM = 4;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MB = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NM-1:0]     m_req, m_cmd, m_ack;
  logic [NM*AW-1:0]  m_addr;
  logic [NM*DW-1:0]  m_wdata, m_rdata;
  logic              s_cs, s_cmd, s_ack;
  logic [AW-1:0]     s_addr;
  logic [DW-1:0]     s_wdata, s_rdata;

  logic              req_v   [NM];
  logic              cmd_v   [NM];
  logic [AW-1:0]     addr_v  [NM];
  logic [DW-1:0]     wdata_v [NM];
  logic              stall;
  logic [DW-1:0]     mem [16];

  typedef struct {
    int          master;
    bit          is_read;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  slave_arbiter #(
    .NUM_MASTERS (NM),
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .MAX_BURST   (MB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .m_req   (m_req),
    .m_cmd   (m_cmd),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata),
    .m_ack   (m_ack),
    .s_cs    (s_cs),
    .s_cmd   (s_cmd),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_rdata (s_rdata),
    .s_ack   (s_ack)
  );

  always #5 clk = ~clk;

  always_comb begin
    m_req   = '0;
    m_cmd   = '0;
    m_addr  = '0;
    m_wdata = '0;
    for (int i = 0; i < NM; i++) begin
      m_req[i]             = req_v[i];
      m_cmd[i]             = cmd_v[i];
      m_addr[i*AW +: AW]   = addr_v[i];
      m_wdata[i*DW +: DW]  = wdata_v[i];
    end
  end

  // Small RAM slave: zero-wait unless stalled, combinational read.
  assign s_ack   = s_cs & ~stall;
  assign s_rdata = mem[s_addr[3:0]];

  always @(posedge clk) begin
    if (s_cs && s_ack && s_cmd) mem[s_addr[3:0]] <= s_wdata;
  end

  task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // One master performing n transfers, holding req until the last ack.
  task automatic applyStimulus(input int idx, input int n, input logic cmd,
                               input logic [AW-1:0] base_addr, input logic [DW-1:0] base_data);
    int   done;
    int   budget;
    logic acked;
    done   = 0;
    budget = 200;
    @(posedge clk); #1;
    req_v[idx]   = 1'b1;
    cmd_v[idx]   = cmd;
    addr_v[idx]  = base_addr;
    wdata_v[idx] = base_data;
    while (done < n && budget > 0) begin
      @(negedge clk);
      acked = m_ack[idx];
      budget--;
      @(posedge clk); #1;
      if (acked) begin
        done++;
        if (done == n) begin
          req_v[idx] = 1'b0;
        end else begin
          addr_v[idx]  = base_addr + AW'(done);
          wdata_v[idx] = base_data + DW'(done);
        end
      end
    end
    req_v[idx] = 1'b0;
    checkOutput($sformatf("m%0d_transfers_done", idx), done, n);
  endtask

  task automatic apply_reset();
    rst   = 1'b1;
    stall = 1'b0;
    for (int i = 0; i < NM; i++) req_v[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic push_exp(input int master, input bit is_read, input logic [DW-1:0] rdata);
    exp_t e;
    e.master  = master;
    e.is_read = is_read;
    e.rdata   = rdata;
    exp_q.push_back(e);
  endtask

  // Monitor: every acknowledge consumes one scoreboard entry.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        checkOutput("ack_onehot", ($countones(m_ack) <= 1) ? 32'd1 : 32'd0, 32'd1);
        for (int i = 0; i < NM; i++) begin
          if (m_ack[i]) begin
            if (exp_q.size() == 0) begin
              tests_run++;
              tests_failed++;
              $display("[TB] FAIL unexpected_ack: got ack on master %0d, expected none", i);
            end else begin
              e = exp_q.pop_front();
              checkOutput("grant_master", i, e.master);
              if (e.is_read) checkOutput("read_data", m_rdata[i*DW +: DW], e.rdata);
              for (int j = 0; j < NM; j++) begin
                if (j != i) checkOutput($sformatf("rdata_slice_%0d", j), m_rdata[j*DW +: DW], '0);
              end
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin : stimulus
    int acks;
    int budget;
    rst   = 1'b1;
    stall = 1'b0;
    for (int i = 0; i < NM; i++) begin
      req_v[i]   = 1'b0;
      cmd_v[i]   = 1'b0;
      addr_v[i]  = '0;
      wdata_v[i] = '0;
    end
    #1;
    checkOutput("reset_s_cs", s_cs, 0);
    checkOutput("reset_m_ack", m_ack, 0);
    checkOutput("reset_m_rdata", (m_rdata == '0) ? 32'd1 : 32'd0, 32'd1);
    apply_reset();

    // Write then read back through master 0.
    push_exp(0, 1'b0, '0);
    push_exp(0, 1'b1, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    req_v[0] = 1'b1; cmd_v[0] = 1'b1; addr_v[0] = 32'd3; wdata_v[0] = 32'hDEAD_BEEF;
    @(negedge clk);
    checkOutput("a_cs_idle", s_cs, 0);
    @(negedge clk);
    checkOutput("a_cs_rise", s_cs, 1);
    checkOutput("a_s_addr", s_addr, 32'd3);
    checkOutput("a_s_wdata", s_wdata, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    cmd_v[0] = 1'b0;
    @(negedge clk);
    checkOutput("a_s_cmd_read", s_cmd, 0);
    @(posedge clk); #1;
    req_v[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // All four request once: strict rotation from master 0.
    apply_reset();
    for (int i = 0; i < NM; i++) push_exp(i, 1'b0, '0);
    fork
      applyStimulus(0, 1, 1'b1, 32'h0, 32'hA0);
      applyStimulus(1, 1, 1'b1, 32'h1, 32'hA1);
      applyStimulus(2, 1, 1'b1, 32'h2, 32'hA2);
      applyStimulus(3, 1, 1'b1, 32'h3, 32'hA3);
    join
    repeat (3) @(posedge clk);
    #1;

    // Burst limit: master 1 is cut after four acks, master 2 slips in.
    apply_reset();
    for (int i = 0; i < 4; i++) push_exp(1, 1'b0, '0);
    push_exp(2, 1'b0, '0);
    push_exp(1, 1'b0, '0);
    push_exp(1, 1'b0, '0);
    fork
      applyStimulus(1, 6, 1'b1, 32'h0, 32'h1000);
      applyStimulus(2, 1, 1'b1, 32'h8, 32'h2000);
      begin
        for (int k = 0; k < 8; k++) begin
          @(posedge clk); #1;
          stall = k[0];
        end
        stall = 1'b0;
      end
    join
    repeat (3) @(posedge clk);
    #1;
    checkOutput("c_mem_m1_last", mem[5], 32'h1005);
    checkOutput("c_mem_m2", mem[8], 32'h2000);
    checkOutput("c_ptr", dut.ptr, 2);

    // One-cycle pulse from master 3: grant taken but slave never selected.
    @(posedge clk); #1;
    req_v[3] = 1'b1; cmd_v[3] = 1'b1; addr_v[3] = 32'hC; wdata_v[3] = 32'h5555;
    @(negedge clk);
    checkOutput("d_cs_cycle0", s_cs, 0);
    @(posedge clk); #1;
    req_v[3] = 1'b0;
    @(negedge clk);
    checkOutput("d_cs_cycle1", s_cs, 0);
    checkOutput("d_grant_idx", dut.grant_idx, 3);
    @(negedge clk);
    checkOutput("d_cs_cycle2", s_cs, 0);
    checkOutput("d_ptr", dut.ptr, 0);
    checkOutput("d_mem_untouched", mem[12], 32'h0);

    // Reset in the middle of a master 2 burst.
    apply_reset();
    push_exp(2, 1'b0, '0);
    push_exp(2, 1'b0, '0);
    @(posedge clk); #1;
    req_v[2] = 1'b1; cmd_v[2] = 1'b1; addr_v[2] = 32'h9; wdata_v[2] = 32'h3000;
    acks   = 0;
    budget = 50;
    while (acks < 2 && budget > 0) begin
      @(negedge clk);
      if (m_ack[2]) acks++;
      budget--;
    end
    checkOutput("e_two_acks", acks, 2);
    @(posedge clk); #1;
    checkOutput("e_cs_before_rst", s_cs, 1);
    checkOutput("e_burst_cnt", dut.burst_cnt, 2);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("e_cs_async", s_cs, 0);
    checkOutput("e_ack_async", m_ack, 0);
    checkOutput("e_rdata_async", (m_rdata == '0) ? 32'd1 : 32'd0, 32'd1);
    req_v[2] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < NM; i++) push_exp(i, 1'b0, '0);
    fork
      applyStimulus(0, 1, 1'b1, 32'h4, 32'hB0);
      applyStimulus(1, 1, 1'b1, 32'h5, 32'hB1);
      applyStimulus(2, 1, 1'b1, 32'h6, 32'hB2);
      applyStimulus(3, 1, 1'b1, 32'h7, 32'hB3);
    join
    repeat (3) @(posedge clk);
    #1;

    checkOutput("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
